// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer: plays fixed note sequences for game events as a square wave (optional mute input via BUZZER_MUTE_EN)
module buzzer_sequencer #(
  parameter int TICK_DIV   = 25000,
  parameter int NOTE_TICKS = 100,
  parameter int GAP_TICKS  = 20,
  parameter int TONE_SHIFT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic evt_drop,
  input  logic evt_invalid,
  input  logic evt_win,
`ifdef BUZZER_MUTE_EN
  input  logic mute,
`endif
  output logic buzzer_out,
  output logic busy,
  output logic done
);
  localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_GAP = 2'd2;
  localparam logic [1:0] Q_DROP = 2'd0, Q_INV = 2'd1, Q_WIN = 2'd2;
  localparam logic [15:0] HP_A3 = 16'd56818, HP_C5 = 16'd23901, HP_E5 = 16'd18968,
                          HP_G5 = 16'd15944, HP_C6 = 16'd11939;
  localparam logic [31:0] TD_LAST  = 32'(TICK_DIV - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_TICKS - 1);

  logic [1:0]  state_q, state_d, seq_q, seq_d, idx_q, idx_d;
  logic [31:0] pre_q, pre_d, tick_q, tick_d;
  logic [15:0] hp_q, hp_d;
  logic        buz_q, buz_d, done_q, done_d;
  logic        pre_end, seg_end, win_go, idle_go;
  logic [1:0]  new_seq;

  function automatic logic [15:0] half_of(input logic [1:0] sq, input logic [1:0] ix);
    logic [15:0] raw, sh;
    raw = sq == Q_DROP ? HP_C6 : sq == Q_INV ? HP_A3 :
          ix == 2'd0 ? HP_C5 : ix == 2'd1 ? HP_E5 : ix == 2'd2 ? HP_G5 : HP_C6;
    sh = raw >> TONE_SHIFT;
    return sh == 16'd0 ? 16'd1 : sh;
  endfunction

  function automatic logic [31:0] last_tick_of(input logic [1:0] sq, input logic [1:0] ix);
    return (sq == Q_WIN && ix == 2'd3) ? 32'(2 * NOTE_TICKS - 1) : 32'(NOTE_TICKS - 1);
  endfunction

  function automatic logic last_of(input logic [1:0] sq, input logic [1:0] ix);
    return ix == (sq == Q_DROP ? 2'd0 : sq == Q_INV ? 2'd1 : 2'd3);
  endfunction

  // next-state: event acceptance, segment timing and tone toggling
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    tick_d  = tick_q;
    hp_d    = hp_q;
    buz_d   = buz_q;
    done_d  = 1'b0;
    pre_end = pre_q == TD_LAST;
    seg_end = pre_end && tick_q == (state_q == S_PLAY ? last_tick_of(seq_q, idx_q) : GAP_LAST);
    win_go  = evt_win && !(state_q != S_IDLE && seq_q == Q_WIN);
    idle_go = state_q == S_IDLE && (evt_win || evt_invalid || evt_drop);
    new_seq = evt_win ? Q_WIN : evt_invalid ? Q_INV : Q_DROP;
    if (win_go || idle_go) begin
      state_d = S_PLAY;
      seq_d   = new_seq;
      idx_d   = 2'd0;
      pre_d   = '0;
      tick_d  = '0;
      hp_d    = half_of(new_seq, 2'd0) - 16'd1;
      buz_d   = 1'b0;
    end else if (state_q != S_IDLE) begin
      pre_d  = pre_end ? '0 : pre_q + 32'd1;
      tick_d = pre_end ? tick_q + 32'd1 : tick_q;
      if (state_q == S_PLAY) begin
        hp_d  = hp_q == 16'd0 ? half_of(seq_q, idx_q) - 16'd1 : hp_q - 16'd1;
        buz_d = hp_q == 16'd0 ? ~buz_q : buz_q;
      end
      if (seg_end) begin
        pre_d  = '0;
        tick_d = '0;
        buz_d  = 1'b0;
        if (state_q == S_GAP) begin
          state_d = S_PLAY;
          idx_d   = idx_q + 2'd1;
          hp_d    = half_of(seq_q, idx_q + 2'd1) - 16'd1;
        end else begin
          state_d = last_of(seq_q, idx_q) ? S_IDLE : S_GAP;
          done_d  = last_of(seq_q, idx_q);
        end
      end
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      seq_q   <= Q_DROP;
      idx_q   <= '0;
      pre_q   <= '0;
      tick_q  <= '0;
      hp_q    <= '0;
      buz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      hp_q    <= hp_d;
      buz_q   <= buz_d;
      done_q  <= done_d;
    end
  end

  assign busy = state_q != S_IDLE;
  assign done = done_q;
`ifdef BUZZER_MUTE_EN
  assign buzzer_out = buz_q & ~mute;
`else
  assign buzzer_out = buz_q;
`endif
endmodule

// File: tb/tb_buzzer_sequencer.sv
// tb_buzzer_sequencer: directed and random events checked against a segment-list reference model
module tb_buzzer_sequencer;
  localparam int TD = 100, NT = 4, GT = 2, TS = 8;
  logic clk = 1'b0, rst = 1'b1, evt_drop = 1'b0, evt_invalid = 1'b0, evt_win = 1'b0;
  logic buzzer_out, busy, done;
`ifdef BUZZER_MUTE_EN
  logic mute = 1'b0;
`endif
  int n_chk = 0, n_fail = 0;
  bit m_act = 0, m_win = 0, m_done = 0;
  int qh[$], ql[$];
  int si = 0, k = 0;

  always #5 clk = ~clk;

  buzzer_sequencer #(.TICK_DIV(TD), .NOTE_TICKS(NT), .GAP_TICKS(GT), .TONE_SHIFT(TS)) dut (
    .clk(clk), .rst(rst), .evt_drop(evt_drop), .evt_invalid(evt_invalid), .evt_win(evt_win),
`ifdef BUZZER_MUTE_EN
    .mute(mute),
`endif
    .buzzer_out(buzzer_out), .busy(busy), .done(done));

  function automatic int hp(input int raw);
    int v = raw >> TS;
    return v == 0 ? 1 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic seg(input int h, input int len);
    qh.push_back(h);
    ql.push_back(len);
  endtask

  task automatic load(input bit w, input bit inv);
    qh.delete();
    ql.delete();
    si = 0; k = 0; m_act = 1; m_win = w;
    if (w) begin
      seg(hp(23901), NT*TD); seg(0, GT*TD); seg(hp(18968), NT*TD); seg(0, GT*TD);
      seg(hp(15944), NT*TD); seg(0, GT*TD); seg(hp(11939), 2*NT*TD);
    end else if (inv) begin
      seg(hp(56818), NT*TD); seg(0, GT*TD); seg(hp(56818), NT*TD);
    end else seg(hp(11939), NT*TD);
  endtask

  task automatic cyc(input bit d, input bit i, input bit w, input bit r);
    logic eb;
    @(negedge clk);
    evt_drop = d; evt_invalid = i; evt_win = w; rst = r;
    @(posedge clk);
    m_done = 0;
    if (r) m_act = 0;
    else if (w && !(m_act && m_win)) load(1, 0);
    else if (!m_act && (i || d)) load(0, i);
    else if (m_act) begin
      k++;
      if (k == ql[si]) begin
        si++; k = 0;
        if (si == qh.size()) begin m_act = 0; m_done = 1; end
      end
    end
    #1;
    eb = (m_act && qh[si] != 0) ? 1'((k / qh[si]) % 2) : 1'b0;
`ifdef BUZZER_MUTE_EN
    eb = eb & ~mute;
`endif
    chk("busy", 32'(busy), 32'(m_act));
    chk("done", 32'(done), 32'(m_done));
    chk("buzzer_out", 32'(buzzer_out), 32'(eb));
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) cyc(0, 0, 0, 1);
    idle(1000);
    cyc(0, 0, 1, 0); idle(500); cyc(0, 0, 0, 1); idle(10);
    cyc(1, 0, 0, 0); idle(420);
    cyc(0, 1, 0, 0); idle(1020);
    cyc(0, 0, 1, 0); idle(2620);
    cyc(1, 0, 1, 0); idle(2620);
    cyc(1, 1, 0, 0); idle(1020);
    cyc(1, 0, 0, 0); idle(150); cyc(0, 0, 1, 0); idle(300); cyc(1, 0, 0, 0); idle(2400);
    cyc(0, 1, 0, 0); idle(800); cyc(0, 0, 1, 0); idle(2620);
    cyc(1, 0, 0, 0); idle(400); cyc(1, 0, 0, 0); idle(420);
`ifdef BUZZER_MUTE_EN
    mute = 1'b1; cyc(1, 0, 0, 0); idle(420);
    cyc(1, 0, 0, 0); idle(100); mute = 1'b0; idle(320);
    mute = 1'b0;
`endif
    for (int j = 0; j < 20000; j++) begin
      int r = $urandom_range(0, 249);
`ifdef BUZZER_MUTE_EN
      if ($urandom_range(0, 499) == 0) mute = ~mute;
`endif
      cyc(r == 0 || r == 3, r == 1 || r == 3, r == 2 || r == 3, $urandom_range(0, 3999) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
